// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller (pipe_ctrl).
package pipe_ctrl_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    localparam int DEF_NUM_STAGES  = 5;
    localparam int DEF_MC_STAGE    = 3;
    localparam int DEF_CNT_W       = 6;
    localparam int DEF_FLUSH_DEPTH = 4;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;

endpackage

// File: rtl/pipe_ctrl_mc_counter.sv
// Multi-cycle operation tracker: IDLE/MC_BUSY FSM with a down-counter that
// holds the issuing stage for the requested number of cycles.
module pipe_mc_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cycles,
    input  logic             abort,
    output logic             busy,
    output logic             done
);

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        // NOTE: blocking '=' in always_comb; later statements see earlier
        // values within the same evaluation, as combinational logic should.
        unique case (state_q)
            IDLE: begin
                if (start && (cycles != '0) && !abort) begin
                    state_d = MC_BUSY;
                    cnt_d   = cycles - CNT_W'(1);
                    done_d  = (cycles == CNT_W'(1));
                end
            end
            MC_BUSY: begin
                if (abort || (cnt_q == '0)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    done_d = (cnt_q == CNT_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking '<=' for state so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == MC_BUSY);
    // A flush in the final busy cycle cancels the completion pulse.
    assign done = done_q & ~abort;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/bubble/flush controller with multi-cycle operation support.
// Optional stall statistics counter enabled by defining PIPE_CTRL_STATS_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int MC_STAGE    = DEF_MC_STAGE,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_STAGES-1:0] i_stall_req,
    input  logic                  i_mc_start,
    input  logic [CNT_W-1:0]      i_mc_cycles,
    input  logic                  i_flush,
    output logic [NUM_STAGES-1:0] o_stall,
    output logic [NUM_STAGES-1:0] o_bubble,
    output logic [NUM_STAGES-1:0] o_flush,
    output logic                  o_mc_busy,
    output logic                  o_mc_done,
    output logic [31:0]           o_stall_cycles
);

    logic [NUM_STAGES-1:0] req;

    pipe_mc_counter #(
        .CNT_W (CNT_W)
    ) u_mc_counter (
        .clk    (i_clk),
        .rst    (i_rst),
        .start  (i_mc_start),
        .cycles (i_mc_cycles),
        .abort  (i_flush),
        .busy   (o_mc_busy),
        .done   (o_mc_done)
    );

    // The PC stage has nothing upstream to hold, so its request is dropped.
    always_comb begin
        req    = i_stall_req;
        req[0] = 1'b0;
        if (o_mc_busy) req[MC_STAGE] = 1'b1;
    end

    // Ascending scan: the highest requesting stage is the last one to write.
    always_comb begin
        o_stall  = '0;
        o_bubble = '0;
        o_flush  = '0;
        if (i_flush) begin
            for (int j = 0; j < FLUSH_DEPTH; j++) o_flush[j] = 1'b1;
        end else begin
            for (int j = 0; j < NUM_STAGES; j++) begin
                if (req[j]) begin
                    o_bubble    = '0;
                    o_bubble[j] = 1'b1;
                    o_stall     = NUM_STAGES'((1 << j) - 1);
                end
            end
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
        end else if (o_stall[0] && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_stall_cycles = stall_cnt_q;
`else
    assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl at default parameters: comb decode table
// plus multi-cycle, flush, reset and statistics sequences.
module tb_pipe_ctrl;

    localparam int NS = 5;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] stall_req;
    logic          mc_start;
    logic [CW-1:0] mc_cycles;
    logic          flush;
    logic [NS-1:0] stall, bubble, flush_o;
    logic          mc_busy, mc_done;
    logic [31:0]   stall_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         name;
        logic          rst;
        logic [NS-1:0] req;
        logic          start;
        logic [CW-1:0] cyc;
        logic          flush;
        logic [NS-1:0] e_stall;
        logic [NS-1:0] e_bubble;
        logic [NS-1:0] e_flush;
        logic          e_busy;
        logic          e_done;
    } vec_t;

    vec_t exp_q[$];

    pipe_ctrl dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall_req    (stall_req),
        .i_mc_start     (mc_start),
        .i_mc_cycles    (mc_cycles),
        .i_flush        (flush),
        .o_stall        (stall),
        .o_bubble       (bubble),
        .o_flush        (flush_o),
        .o_mc_busy      (mc_busy),
        .o_mc_done      (mc_done),
        .o_stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic [NS-1:0] req,
                                input logic st, input logic [CW-1:0] cyc, input logic fl,
                                input logic [NS-1:0] es, input logic [NS-1:0] eb,
                                input logic [NS-1:0] ef, input logic ebusy, input logic edone);
        vec_t v;
        v.name = name; v.rst = r; v.req = req; v.start = st; v.cyc = cyc; v.flush = fl;
        v.e_stall = es; v.e_bubble = eb; v.e_flush = ef; v.e_busy = ebusy; v.e_done = edone;
        return v;
    endfunction

    // One cycle: drive at negedge, queue the expectation, compare before the posedge.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst       = v.rst;
        stall_req = v.req;
        mc_start  = v.start;
        mc_cycles = v.cyc;
        flush     = v.flush;
        exp_q.push_back(v);
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, ".stall"},  32'(stall),   32'(e.e_stall));
            check({e.name, ".bubble"}, 32'(bubble),  32'(e.e_bubble));
            check({e.name, ".flush"},  32'(flush_o), 32'(e.e_flush));
            check({e.name, ".busy"},   32'(mc_busy), 32'(e.e_busy));
            check({e.name, ".done"},   32'(mc_done), 32'(e.e_done));
        end
    endtask

    task automatic idle(input string name, input logic ebusy, input logic edone);
        if (ebusy) apply(mk(name, 0, 5'b00000, 0, 6'd0, 0, 5'b00111, 5'b01000, 5'b00000, 1, edone));
        else       apply(mk(name, 0, 5'b00000, 0, 6'd0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0));
    endtask

    task automatic do_reset();
        apply(mk("rst_a", 1, 5'b00000, 0, 6'd0, 0, 5'b00000, 5'b00000, 5'b00000, 1'bx, 1'bx));
    endtask

    vec_t tbl[11];
    logic [31:0] exp_stats;

    initial begin
        rst = 1'b1; stall_req = '0; mc_start = 1'b0; mc_cycles = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("reset.stall",  32'(stall),   32'd0);
        check("reset.bubble", 32'(bubble),  32'd0);
        check("reset.flush",  32'(flush_o), 32'd0);
        check("reset.busy",   32'(mc_busy), 32'd0);
        check("reset.done",   32'(mc_done), 32'd0);
        check("reset.stats",  stall_cycles, 32'd0);

        // Combinational decode with the FSM idle.
        tbl[0]  = mk("none",     0, 5'b00000, 0, 6'd0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0);
        tbl[1]  = mk("pc_only",  0, 5'b00001, 0, 6'd0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0);
        tbl[2]  = mk("ex",       0, 5'b01000, 0, 6'd0, 0, 5'b00111, 5'b01000, 5'b00000, 0, 0);
        tbl[3]  = mk("id",       0, 5'b00100, 0, 6'd0, 0, 5'b00011, 5'b00100, 5'b00000, 0, 0);
        tbl[4]  = mk("mem",      0, 5'b10000, 0, 6'd0, 0, 5'b01111, 5'b10000, 5'b00000, 0, 0);
        tbl[5]  = mk("if",       0, 5'b00010, 0, 6'd0, 0, 5'b00001, 5'b00010, 5'b00000, 0, 0);
        tbl[6]  = mk("ex_if",    0, 5'b01010, 0, 6'd0, 0, 5'b00111, 5'b01000, 5'b00000, 0, 0);
        tbl[7]  = mk("all",      0, 5'b11111, 0, 6'd0, 0, 5'b01111, 5'b10000, 5'b00000, 0, 0);
        tbl[8]  = mk("flush_rq", 0, 5'b11111, 0, 6'd0, 1, 5'b00000, 5'b00000, 5'b01111, 0, 0);
        tbl[9]  = mk("flush",    0, 5'b00000, 0, 6'd0, 1, 5'b00000, 5'b00000, 5'b01111, 0, 0);
        tbl[10] = mk("id_if",    0, 5'b00110, 0, 6'd0, 0, 5'b00011, 5'b00100, 5'b00000, 0, 0);
        for (int i = 0; i < 11; i++) apply(tbl[i]);

        // Length-4 operation: busy for 4 cycles, done on the 4th.
        apply(mk("mc4_start", 0, 5'b00000, 1, 6'd4, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        idle("mc4_b1", 1, 0);
        idle("mc4_b2", 1, 0);
        idle("mc4_b3", 1, 0);
        idle("mc4_b4", 1, 1);
        idle("mc4_end", 0, 0);

        // Length-1 operation.
        apply(mk("mc1_start", 0, 5'b00000, 1, 6'd1, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        idle("mc1_b1", 1, 1);
        idle("mc1_end", 0, 0);

        // Flush in the 2nd cycle of a 6-cycle operation.
        apply(mk("mc6_start", 0, 5'b00000, 1, 6'd6, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        idle("mc6_b1", 1, 0);
        apply(mk("mc6_flush", 0, 5'b00000, 0, 6'd0, 1, 5'b00000, 5'b00000, 5'b01111, 1, 0));
        idle("mc6_after1", 0, 0);
        idle("mc6_after2", 0, 0);

        // Flush in the same cycle the counter expires: no done pulse.
        apply(mk("mc2_start", 0, 5'b00000, 1, 6'd2, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        idle("mc2_b1", 1, 0);
        apply(mk("mc2_flush", 0, 5'b00000, 0, 6'd0, 1, 5'b00000, 5'b00000, 5'b01111, 1, 0));
        idle("mc2_after", 0, 0);

        // Start together with flush in IDLE is dropped.
        apply(mk("fl_start", 0, 5'b00000, 1, 6'd3, 1, 5'b00000, 5'b00000, 5'b01111, 0, 0));
        idle("fl_start_after", 0, 0);

        // Zero-length start is ignored; a start while busy is ignored.
        apply(mk("mc0_start", 0, 5'b00000, 1, 6'd0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        idle("mc0_after", 0, 0);
        apply(mk("mc3_start", 0, 5'b00000, 1, 6'd3, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        apply(mk("mc3_restart", 0, 5'b00000, 1, 6'd5, 0, 5'b00111, 5'b01000, 5'b00000, 1, 0));
        idle("mc3_b2", 1, 0);
        idle("mc3_b3", 1, 1);
        idle("mc3_end", 0, 0);
        idle("mc3_end2", 0, 0);

        // Reset in the 3rd busy cycle aborts without done.
        apply(mk("rs_start", 0, 5'b00000, 1, 6'd6, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0));
        idle("rs_b1", 1, 0);
        idle("rs_b2", 1, 0);
        apply(mk("rs_b3_rst", 1, 5'b00000, 0, 6'd0, 0, 5'b00111, 5'b01000, 5'b00000, 1, 0));
        idle("rs_after", 0, 0);
        check("rs_after.stats", stall_cycles, 32'd0);

        // Ten stall cycles after reset.
        for (int i = 0; i < 10; i++)
            apply(mk("stat_run", 0, 5'b01000, 0, 6'd0, 0, 5'b00111, 5'b01000, 5'b00000, 0, 0));
        idle("stat_end", 0, 0);
`ifdef PIPE_CTRL_STATS_EN
        exp_stats = 32'd10;
`else
        exp_stats = 32'd0;
`endif
        check("stat_count", stall_cycles, exp_stats);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
